// File: rtl/fifo_ctrl.sv
// Purpose : pointer/count/flag controller that turns a sync-write, async-read
//           two-port RAM into a first-word-fall-through FIFO; never touches data.
// Latency : write visible to the consumer one cycle after the write edge; we is
//           combinational. Backpressure: writes rejected when full unless a read
//           is accepted in the same cycle; reads rejected when empty; rejections
//           set the sticky overflow/underflow bits.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   wr, rd              producer push / consumer pop requests
//   err_clr             synchronous clear of overflow/underflow (a new error wins)
//   we, w_addr, r_addr  RAM control: write enable, write pointer, head pointer
//   full, empty, almost_full, almost_empty, count
//                       registered occupancy status
//   overflow, underflow sticky error bits
module fifo_ctrl #(
    parameter int addr_width = 3,
    parameter int af_level   = 6,
    parameter int ae_level   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  err_clr,
    output logic                  we,
    output logic [addr_width-1:0] w_addr,
    output logic [addr_width-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = addr_width + 1;
    localparam logic [addr_width:0] DEPTH  = CW'(1 << addr_width);
    localparam logic [addr_width:0] AF_LVL = CW'(af_level);
    localparam logic [addr_width:0] AE_LVL = CW'(ae_level);

    logic [addr_width-1:0] wptr_q, wptr_d;
    logic [addr_width-1:0] rptr_q, rptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_acc;
    logic                  wr_acc;

    // Acceptance depends only on registered state, so there is no
    // combinational path from wr/rd into the flags or count.
    // Gating with reset keeps the RAM write enable low while reset is held.
    always_comb begin
        rd_acc = rd & ~empty_q & ~reset;
        wr_acc = wr & (~full_q | rd_acc) & ~reset;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        // Pointers wrap modulo depth through natural overflow.
        if (wr_acc) wptr_d = wptr_q + 1'b1;
        if (rd_acc) rptr_d = rptr_q + 1'b1;

        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);

        // Flags come from the next count so they move on the same edge as count.
        full_d  = (count_d == DEPTH);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_LVL);
        ae_d    = (count_d <= AE_LVL);

        // A new error event in the same cycle as err_clr keeps the bit set.
        ovf_d = (wr & ~wr_acc) | (ovf_q & ~err_clr);
        unf_d = (rd & ~rd_acc) | (unf_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign we           = wr_acc;
    assign w_addr       = wptr_q;
    assign r_addr       = rptr_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Purpose : self-checking bench for fifo_ctrl with a behavioural RAM attached.
// Latency : read data is checked by a scoreboard monitor on the falling edge.
// Backpressure: expected acceptance of every request is supplied by the stimulus.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       err_clr = 1'b0;
    logic       we;
    logic [2:0] w_addr;
    logic [2:0] r_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    logic [7:0] wdata = 8'h00;
    logic [7:0] mem [8];
    logic [7:0] r_data;
    logic       rd_ok = 1'b0;
    logic       we_seen;

    logic [7:0] sb_q [$];
    int checks = 0;
    int failures = 0;

    fifo_ctrl #(.addr_width(3), .af_level(6), .ae_level(1)) dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .err_clr(err_clr),
        .we(we), .w_addr(w_addr), .r_addr(r_addr), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Two-port RAM: synchronous write, asynchronous read.
    always @(posedge clk) if (we) mem[w_addr] <= wdata;
    assign r_data = mem[r_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every read the stimulus expects to succeed pops the scoreboard.
    always @(negedge clk) begin
        if (rd && rd_ok && !reset) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_data: read with empty scoreboard, got 0x%0h", r_data);
            end else begin
                chk("rd_data", int'(r_data), int'(sb_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; wok/rok are the hand-derived acceptance outcomes.
    task automatic drive(input logic w, input logic r, input logic [7:0] d,
                         input logic wok, input logic rok);
        wr = w; rd = r; wdata = d; rd_ok = rok;
        if (wok) sb_q.push_back(d);
        @(negedge clk);
        we_seen = we;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; rd_ok = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        // Reset state, with wr held high to show we is gated.
        wr = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_we", int'(we), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_af", int'(almost_full), 0);
        wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1. Asynchronous reset mid-cycle with 3 entries held.
        for (int i = 0; i < 3; i++) drive(1, 0, 8'hA0 + 8'(i), 1, 0);
        chk("t1_count3", int'(count), 3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_count", int'(count), 0);
        chk("t1_empty", int'(empty), 1);
        chk("t1_ae", int'(almost_empty), 1);
        chk("t1_waddr", int'(w_addr), 0);
        chk("t1_raddr", int'(r_addr), 0);
        chk("t1_we", int'(we), 0);
        chk("t1_err", int'({overflow, underflow}), 0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 2. Fill with 9 writes; the 9th is rejected.
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 8'h10 + 8'(i), i < 8, 0);
            chk("t2_we", int'(we_seen), (i < 8) ? 1 : 0);
            chk("t2_af", int'(almost_full), (i >= 5) ? 1 : 0);
            chk("t2_full", int'(full), (i >= 7) ? 1 : 0);
            chk("t2_count", int'(count), (i < 8) ? i + 1 : 8);
        end
        chk("t2_waddr", int'(w_addr), 0);
        chk("t2_ovf", int'(overflow), 1);
        err_clr = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        chk("t2_ovf_clr", int'(overflow), 0);

        // 3. Drain with 9 reads; the 9th is rejected.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 8'h00, 0, i < 8);
            chk("t3_count", int'(count), (i < 8) ? 7 - i : 0);
            chk("t3_ae", int'(almost_empty), (i >= 6) ? 1 : 0);
            chk("t3_empty", int'(empty), (i >= 7) ? 1 : 0);
        end
        chk("t3_raddr", int'(r_addr), 0);
        chk("t3_unf", int'(underflow), 1);
        chk("t3_ovf", int'(overflow), 0);
        err_clr = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        chk("t3_unf_clr", int'(underflow), 0);

        // 4. Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) drive(1, 0, 8'h20 + 8'(i), 1, 0);
        chk("t4_full0", int'(full), 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h28 + 8'(i), 1, 1);
            chk("t4_we", int'(we_seen), 1);
            chk("t4_count", int'(count), 8);
            chk("t4_full", int'(full), 1);
            chk("t4_ovf", int'(overflow), 0);
        end
        chk("t4_waddr", int'(w_addr), 4);
        chk("t4_raddr", int'(r_addr), 4);
        for (int i = 0; i < 8; i++) drive(0, 1, 8'h00, 0, 1);
        chk("t4_empty", int'(empty), 1);

        // 5. Simultaneous read and write while empty.
        drive(1, 1, 8'h55, 1, 0);
        chk("t5_we", int'(we_seen), 1);
        chk("t5_unf", int'(underflow), 1);
        chk("t5_count", int'(count), 1);
        drive(0, 1, 8'h00, 0, 1);
        chk("t5_empty", int'(empty), 1);
        err_clr = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        chk("t5_unf_clr", int'(underflow), 0);

        // 6. Wrap-around streaming at constant occupancy 3 (pointers start at 5).
        for (int i = 0; i < 3; i++) drive(1, 0, 8'h60 + 8'(i), 1, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 8'h63 + 8'(i), 1, 1);
            chk("t6_count", int'(count), 3);
        end
        chk("t6_waddr", int'(w_addr), 4);
        chk("t6_raddr", int'(r_addr), 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 8'h00, 0, 1);
        chk("t6_empty", int'(empty), 1);
        chk("t6_err", int'({overflow, underflow}), 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
